tick_timer: RTL and testbench

TICK_TIMER -- requirements
Module: tick_timer

---
 rtl/tick_timer.sv | 155 +++++++++++++++
 tb/tb_tick_timer.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/tick_timer.sv
// tick_timer: counts upstream tick strobes toward a programmable period.
// It raises a registered one-cycle expired pulse for each completed run
// and can re-arm itself after each expiry.
//
// Ports
//   clk          rising-edge clock
//   reset        synchronous, active-high reset
//   tick         one-cycle strobe from the upstream pulse generator
//   start        level; starts (IDLE) or restarts (RUN/PAUSE) a run
//   stop         level; aborts a run, keeps exp_cnt
//   pause        level; freezes counting while in RUN/PAUSE
//   auto_reload  re-arm with a freshly sampled period after expiry
//   period       ticks per run, sampled only at start and at reload
//   busy         high in RUN or PAUSE
//   count        ticks counted in the current run
//   expired      one-cycle pulse per completed run
//   exp_cnt      saturating expiry count (cleared by a start from IDLE)
//
// State table
//   IDLE  | no run armed; ticks ignored
//   RUN   | counting ticks toward period_q
//   PAUSE | run armed, count frozen until pause drops
module tick_timer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick,
  input  logic             start,
  input  logic             stop,
  input  logic             pause,
  input  logic             auto_reload,
  input  logic [WIDTH-1:0] period,
  output logic             busy,
  output logic [WIDTH-1:0] count,
  output logic             expired,
  output logic [7:0]       exp_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] period_q, period_d;
  logic [7:0]       exp_cnt_q, exp_cnt_d;
  logic             expired_q, expired_d;
  logic             busy_q, busy_d;

  logic period_nz;
  logic terminal;

  assign period_nz = |period;
  // period_q is never zero while RUN, so the subtraction cannot wrap there.
  assign terminal  = (count_q == (period_q - ONE));

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    period_d  = period_q;
    exp_cnt_d = exp_cnt_q;
    expired_d = 1'b0;

    if (stop) begin
      state_d = IDLE;
      count_d = '0;
    end else if (start) begin
      if (state_q == IDLE) begin
        // A zero period from IDLE is ignored entirely.
        if (period_nz) begin
          period_d  = period;
          count_d   = '0;
          exp_cnt_d = 8'd0;
          state_d   = RUN;
        end
      end else begin
        // Restart: relatch the period and drop any tick in this cycle.
        // exp_cnt is kept across restarts.
        period_d = period;
        count_d  = '0;
        if (!period_nz) begin
          state_d = IDLE;
        end else if (pause) begin
          state_d = PAUSE;
        end else begin
          state_d = RUN;
        end
      end
    end else begin
      unique case (state_q)
        IDLE: begin
        end
        RUN: begin
          if (pause) begin
            state_d = PAUSE;
          end else if (tick) begin
            if (terminal) begin
              expired_d = 1'b1;
              count_d   = '0;
              if (exp_cnt_q != 8'hFF) begin
                exp_cnt_d = exp_cnt_q + 8'd1;
              end
              if (auto_reload && period_nz) begin
                period_d = period;
              end else begin
                state_d = IDLE;
              end
            end else begin
              count_d = count_q + ONE;
            end
          end
        end
        PAUSE: begin
          if (!pause) begin
            state_d = RUN;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      count_q   <= '0;
      period_q  <= '0;
      exp_cnt_q <= 8'd0;
      expired_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      period_q  <= period_d;
      exp_cnt_q <= exp_cnt_d;
      expired_q <= expired_d;
      busy_q    <= busy_d;
    end
  end

  assign busy    = busy_q;
  assign count   = count_q;
  assign expired = expired_q;
  assign exp_cnt = exp_cnt_q;

endmodule

// File: tb/tb_tick_timer.sv
// Testbench for tick_timer. Stimulus pushes the expected expiry (cycle,
// exp_cnt, busy) onto a queue whenever it issues a terminal tick. A monitor
// pops and compares each time the DUT raises expired.
module tb_tick_timer;

  logic       clk = 1'b0;
  logic       reset;
  logic       tick;
  logic       start;
  logic       stop;
  logic       pause;
  logic       auto_reload;
  logic [7:0] period;
  logic       busy;
  logic [7:0] count;
  logic       expired;
  logic [7:0] exp_cnt;

  tick_timer #(.WIDTH(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .tick        (tick),
    .start       (start),
    .stop        (stop),
    .pause       (pause),
    .auto_reload (auto_reload),
    .period      (period),
    .busy        (busy),
    .count       (count),
    .expired     (expired),
    .exp_cnt     (exp_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  typedef struct packed {
    int         cyc;
    logic [7:0] ec;
    logic       bz;
  } exp_t;

  exp_t sb_q[$];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every expired pulse must match the oldest expected expiry.
  always @(negedge clk) begin
    if (expired === 1'b1) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_expired", 1, 0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("exp_cycle",   cyc,            e.cyc);
        chk("exp_exp_cnt", int'(exp_cnt),  int'(e.ec));
        chk("exp_busy",    int'(busy),     int'(e.bz));
        chk("exp_count",   int'(count),    0);
      end
    end
  end

  task automatic gap(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One-cycle tick; when term is set, the expiry is expected next cycle.
  task automatic do_tick(input bit term, input logic [7:0] ec, input logic bz);
    exp_t e;
    tick = 1'b1;
    if (term) begin
      e.cyc = cyc + 1;
      e.ec  = ec;
      e.bz  = bz;
      sb_q.push_back(e);
    end
    @(negedge clk);
    tick = 1'b0;
  endtask

  task automatic pulse_start(input logic [7:0] p);
    period = p;
    start  = 1'b1;
    gap(1);
    start  = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    gap(1);
    stop = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; tick = 1'b0; start = 1'b0; stop = 1'b0;
    pause = 1'b0; auto_reload = 1'b0; period = 8'd0;
    gap(2);
    reset = 1'b0;
    chk("rst_busy",    int'(busy),    0);
    chk("rst_count",   int'(count),   0);
    chk("rst_expired", int'(expired), 0);
    chk("rst_exp_cnt", int'(exp_cnt), 0);

    // Single run, period 3, tick every 5 clk.
    auto_reload = 1'b0;
    pulse_start(8'd3);
    chk("t1_busy_start",  int'(busy),  1);
    chk("t1_count_start", int'(count), 0);
    for (int i = 0; i < 3; i++) begin
      gap(4);
      do_tick(i == 2, 8'd1, 1'b0);
      chk("t1_count", int'(count), (i == 2) ? 0 : i + 1);
    end
    chk("t1_busy_end",    int'(busy),    0);
    chk("t1_exp_cnt",     int'(exp_cnt), 1);
    gap(1);
    chk("t1_expired_one", int'(expired), 0);

    // Auto-reload, period 2, ten ticks: five expiries 10 clk apart.
    auto_reload = 1'b1;
    pulse_start(8'd2);
    chk("t2_exp_cnt_clr", int'(exp_cnt), 0);
    for (int i = 0; i < 10; i++) begin
      gap(4);
      do_tick(i % 2 == 1, 8'((i + 1) / 2), 1'b1);
    end
    chk("t2_exp_cnt", int'(exp_cnt), 5);
    chk("t2_busy",    int'(busy),    1);
    pulse_stop();
    chk("t2_stop_busy",    int'(busy),    0);
    chk("t2_stop_count",   int'(count),   0);
    chk("t2_stop_exp_cnt", int'(exp_cnt), 5);

    // Pause across two ticks after the first counted tick, period 4.
    auto_reload = 1'b0;
    pulse_start(8'd4);
    gap(4);
    do_tick(1'b0, 8'd0, 1'b0);
    chk("t3_count_1", int'(count), 1);
    pause = 1'b1;
    gap(1);
    for (int i = 0; i < 2; i++) begin
      gap(4);
      do_tick(1'b0, 8'd0, 1'b0);
      chk("t3_count_hold", int'(count), 1);
      chk("t3_busy_pause", int'(busy),  1);
    end
    pause = 1'b0;
    gap(1);
    for (int i = 2; i <= 4; i++) begin
      gap(4);
      do_tick(i == 4, 8'd1, 1'b0);
      chk("t3_count", int'(count), (i == 4) ? 0 : i);
    end

    // Stop and terminal tick in the same cycle; then start with period 0.
    pulse_start(8'd3);
    do_tick(1'b0, 8'd0, 1'b0);
    do_tick(1'b0, 8'd0, 1'b0);
    chk("t4_count_2", int'(count), 2);
    stop = 1'b1; tick = 1'b1;
    gap(1);
    stop = 1'b0; tick = 1'b0;
    chk("t4_busy",    int'(busy),    0);
    chk("t4_count",   int'(count),   0);
    chk("t4_expired", int'(expired), 0);
    gap(1);
    chk("t4_expired_late", int'(expired), 0);
    pulse_start(8'd0);
    chk("t4_zero_busy",  int'(busy),  0);
    chk("t4_zero_count", int'(count), 0);
    gap(1);
    chk("t4_zero_busy2", int'(busy),  0);

    // Period 1, auto-reload, tick held for 300 cycles: saturate at 255.
    auto_reload = 1'b1;
    pulse_start(8'd1);
    for (int i = 0; i < 300; i++) begin
      exp_t e;
      tick  = 1'b1;
      e.cyc = cyc + 1;
      e.ec  = (i + 1 > 255) ? 8'd255 : 8'(i + 1);
      e.bz  = 1'b1;
      sb_q.push_back(e);
      gap(1);
    end
    tick = 1'b0;
    chk("t5_exp_cnt_sat", int'(exp_cnt), 255);
    pulse_stop();

    // Reset during an expired cycle.
    auto_reload = 1'b1;
    pulse_start(8'd2);
    do_tick(1'b0, 8'd0, 1'b1);
    do_tick(1'b1, 8'd1, 1'b1);
    chk("t6_expired_pre", int'(expired), 1);
    reset = 1'b1;
    gap(1);
    reset = 1'b0;
    chk("t6a_busy",    int'(busy),    0);
    chk("t6a_count",   int'(count),   0);
    chk("t6a_expired", int'(expired), 0);
    chk("t6a_exp_cnt", int'(exp_cnt), 0);

    // Reset mid-run at count 5, with back-to-back ticks.
    auto_reload = 1'b0;
    pulse_start(8'd10);
    tick = 1'b1;
    gap(5);
    tick = 1'b0;
    chk("t6_count_5", int'(count), 5);
    reset = 1'b1;
    gap(1);
    reset = 1'b0;
    chk("t6b_busy",    int'(busy),    0);
    chk("t6b_count",   int'(count),   0);
    chk("t6b_expired", int'(expired), 0);
    chk("t6b_exp_cnt", int'(exp_cnt), 0);

    // First start after reset behaves as a normal start from IDLE.
    pulse_start(8'd2);
    chk("t6c_busy", int'(busy), 1);
    do_tick(1'b0, 8'd0, 1'b0);
    do_tick(1'b1, 8'd1, 1'b0);
    chk("t6c_busy_end", int'(busy), 0);

    gap(3);
    chk("sb_drain", sb_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
